uc_multiciclo: RTL
==================

UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum cycles FETCH waits for mem_ack before error.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 opcode  input  6  instruction opcode from instruction register output.
REQ-005 z  input  1  ALU zero flag.
REQ-006 mem_ack  input  1  instruction memory data valid.
REQ-007 mem_req  output  1  instruction fetch request.
REQ-008 we_ir  output  1  instruction register load enable.
REQ-009 we_pc  output  1  PC load enable.
REQ-010 s_inc  output  1  PC source select: 1 = PC+1, 0 = jump target.
REQ-011 s_inm  output  1  register write-data select: 1 = immediate, 0 = ALU.
REQ-012 we3  output  1  register file write enable.
REQ-013 op  output  3  ALU operation.
REQ-014 halted  output  1  sticky halt indicator.
REQ-015 err  output  1  sticky fetch-timeout indicator.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXEC, HALT, ERR.
REQ-017 Opcode classes SHALL be: ALU = xx0xxx; LOAD = xx1000; JUMP = 101001; JZ = 101010; HALTOP = 111111; all others = NOP.
REQ-018 FETCH: mem_req=1; on mem_ack=1, we_ir=1 in the same cycle, next state DECODE, wait counter cleared.
REQ-019 FETCH without mem_ack: wait counter increments; when it reaches TIMEOUT with mem_ack=0, next state ERR.
REQ-020 mem_ack=1 on the cycle the counter equals TIMEOUT SHALL win: next state DECODE, not ERR.
REQ-021 DECODE: registers class and op = opcode[2:0]; no write enables asserted; next state EXEC, or HALT if class = HALTOP.
REQ-022 op SHALL hold the value latched in DECODE until the next DECODE; reset value 3'b000.
REQ-023 EXEC ALU: we3=1, s_inm=0, s_inc=1, we_pc=1.
REQ-024 EXEC LOAD: we3=1, s_inm=1, s_inc=1, we_pc=1.
REQ-025 EXEC JUMP: we3=0, s_inm=0, s_inc=0, we_pc=1.
REQ-026 EXEC JZ: we3=0, s_inm=0, we_pc=1, s_inc = ~z sampled in the EXEC cycle.
REQ-027 EXEC NOP: we3=0, s_inm=0, s_inc=1, we_pc=1.
REQ-028 EXEC SHALL last exactly one cycle, then FETCH; one instruction = 3 cycles + memory wait cycles.
REQ-029 HALT: halted=1, all enables 0, s_inc=1; stays until reset.
REQ-030 ERR: err=1, all enables 0, s_inc=1; stays until reset.
REQ-031 Outside the state where asserted, we3, we_pc, we_ir, mem_req, s_inm SHALL be 0 and s_inc SHALL be 1.
REQ-032 we_pc and we3 SHALL never be asserted in FETCH or DECODE.
REQ-033 Opcode changes outside DECODE SHALL have no effect on outputs, except z in EXEC JZ.

Reset
REQ-034 reset=0 SHALL immediately, without a clock edge, force state FETCH, wait counter 0, op=000, class NOP, and outputs mem_req=0 (registered), we_ir=0, we_pc=0, we3=0, s_inm=0, s_inc=1, halted=0, err=0.
REQ-035 mem_req SHALL first assert on the first rising clk edge after reset deasserts.
REQ-036 Reset asserted in any state, including mid-EXEC, SHALL abort the instruction with no write enable asserted after reset is asserted.

Verification
REQ-037 mem_ack=1 always, opcode=000010 -> we_ir at cycle 1, op=010 from cycle 2, we3=1/we_pc=1/s_inc=1/s_inm=0 at cycle 3, mem_req again at cycle 4.
REQ-038 opcode=001000 -> EXEC shows we3=1, s_inm=1; opcode=101001 -> EXEC shows we3=0, s_inc=0, we_pc=1.
REQ-039 opcode=101010 with z=1 -> s_inc=0 in EXEC; repeat with z=0 -> s_inc=1.
REQ-040 mem_ack held 0 for TIMEOUT cycles -> err=1 and mem_req=0 thereafter; mem_ack arriving at cycle TIMEOUT -> DECODE, err stays 0.
REQ-041 opcode=111111 -> halted=1 after DECODE, all enables 0 for 20 cycles; reset=0 pulse -> halted=0, fetching resumes.
REQ-042 reset=0 asserted between clock edges during EXEC -> we3 and we_pc drop to 0 before the next edge.

Source files
------------

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle control unit: fetch with timeout, decode, one-cycle execute
module uc_multiciclo #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       we_ir,
    output logic       we_pc,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic [2:0] op,
    output logic       halted,
    output logic       err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_ALU,
        C_LOAD,
        C_JUMP,
        C_JZ,
        C_HALT
    } class_t;

    state_t        state_q, state_d;
    class_t        cls_q, cls_d;
    class_t        dec_cls;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    // Low for the first cycle after reset release so mem_req only rises after a real clock edge.
    logic          run_q, run_d;

    // Classify the opcode currently presented by the instruction register.
    always_comb begin
        dec_cls = C_NOP;
        if (opcode[3] == 1'b0) begin
            dec_cls = C_ALU;
        end else if (opcode[3:0] == 4'b1000) begin
            dec_cls = C_LOAD;
        end else if (opcode == 6'b101001) begin
            dec_cls = C_JUMP;
        end else if (opcode == 6'b101010) begin
            dec_cls = C_JZ;
        end else if (opcode == 6'b111111) begin
            dec_cls = C_HALT;
        end
    end

    // State, wait counter, latched class/op and start flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
            cnt_q   <= '0;
            op_q    <= 3'b000;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            run_q   <= run_d;
        end
    end

    // Next-state and Moore/Mealy outputs; everything defaults to the idle values.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        run_d   = 1'b1;
        mem_req = 1'b0;
        we_ir   = 1'b0;
        we_pc   = 1'b0;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        op      = op_q;
        halted  = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        // An ack on the last allowed cycle still wins over the timeout.
                        we_ir   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DECODE;
                    end else if (cnt_q == TMAX) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DECODE: begin
                // op follows the freshly loaded IR during DECODE and is frozen afterwards.
                op      = opcode[2:0];
                op_d    = opcode[2:0];
                cls_d   = dec_cls;
                state_d = (dec_cls == C_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                we_pc = 1'b1;
                case (cls_q)
                    C_ALU:   we3 = 1'b1;
                    C_LOAD: begin
                        we3   = 1'b1;
                        s_inm = 1'b1;
                    end
                    C_JUMP:  s_inc = 1'b0;
                    C_JZ:    s_inc = ~z;
                    default: ;
                endcase
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   err = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

endmodule
